// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding, default phase durations and a
// duration legality helper for the traffic intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    WALK    = 2'd3
  } phase_t;

  localparam int DEF_NUM_DIR       = 2;
  localparam int DEF_TIMER_W       = 8;
  localparam int DEF_GREEN_CYCLES  = 50;
  localparam int DEF_YELLOW_CYCLES = 10;
  localparam int DEF_ALLRED_CYCLES = 4;
  localparam int DEF_WALK_CYCLES   = 20;

  // A duration is usable when it is non-zero and its terminal count fits the timer.
  function automatic bit duration_ok(input int cycles, input int width);
    return (cycles >= 1) && (longint'(cycles) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: free-running phase counter with synchronous clear and a
// terminal-count flag. The owner clears it on the edge that ends a phase,
// so every phase starts counting from zero.
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [TIMER_W-1:0] terminal,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Count up once per cycle; clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/traffic_intersection.sv
// traffic_intersection: round-robin phase controller for NUM_DIR approaches.
// Phases cycle ALL_RED -> GREEN -> YELLOW -> ALL_RED, each lasting its
// parameterised number of cycles. The next green direction is picked
// round-robin from the vehicle demand sampled in the last ALL_RED cycle.
// Optional pedestrian walk phase: define PED_WALK_EN to add ped_req/walk
// ports, a sticky pending flag and a WALK phase inserted after ALL_RED.
module traffic_intersection
  import traffic_pkg::*;
#(
  parameter int NUM_DIR       = DEF_NUM_DIR,
  parameter int TIMER_W       = DEF_TIMER_W,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES,
  parameter int WALK_CYCLES   = DEF_WALK_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset_n,
`ifdef PED_WALK_EN
  input  logic                       ped_req,
  output logic                       walk,
`endif
  input  logic [NUM_DIR-1:0]         veh_req,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [$clog2(NUM_DIR)-1:0] active_dir
);

  localparam int DIR_W = $clog2(NUM_DIR);

  localparam logic [TIMER_W-1:0] ALLRED_TC = TIMER_W'(ALLRED_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GREEN_TC  = TIMER_W'(GREEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] YELLOW_TC = TIMER_W'(YELLOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WALK_TC   = TIMER_W'(WALK_CYCLES - 1);

  // Configuration guards: reject illegal direction counts and durations.
  if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_bad_num_dir
    $error("traffic_intersection: NUM_DIR must be in 2..4");
  end
  if (!duration_ok(GREEN_CYCLES, TIMER_W)) begin : g_bad_green
    $error("traffic_intersection: GREEN_CYCLES must be 1..2**TIMER_W-1");
  end
  if (!duration_ok(YELLOW_CYCLES, TIMER_W)) begin : g_bad_yellow
    $error("traffic_intersection: YELLOW_CYCLES must be 1..2**TIMER_W-1");
  end
  if (!duration_ok(ALLRED_CYCLES, TIMER_W)) begin : g_bad_allred
    $error("traffic_intersection: ALLRED_CYCLES must be 1..2**TIMER_W-1");
  end
  if (!duration_ok(WALK_CYCLES, TIMER_W)) begin : g_bad_walk
    $error("traffic_intersection: WALK_CYCLES must be 1..2**TIMER_W-1");
  end

  phase_t             state;
  phase_t             state_nxt;
  logic               running;
  logic [TIMER_W-1:0] terminal;
  logic               tc;
  logic               phase_end;
  logic               timer_clear;

`ifdef PED_WALK_EN
  logic ped_pending;
  logic after_walk;
  logic enter_walk;
`endif

  // First direction with demand after cur (wrapping, cur itself last);
  // with no demand at all simply advance to cur+1.
  function automatic logic [DIR_W-1:0] rr_pick(input logic [DIR_W-1:0] cur,
                                               input logic [NUM_DIR-1:0] req);
    int   idx;
    logic found;
    rr_pick = DIR_W'((int'(cur) + 1) % NUM_DIR);
    found   = 1'b0;
    for (int i = 1; i <= NUM_DIR; i++) begin
      idx = (int'(cur) + i) % NUM_DIR;
      if (!found && |(req & (NUM_DIR'(1) << idx))) begin
        rr_pick = DIR_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  // The timer holds at zero until the first edge after reset release, so the
  // first full ALL_RED period is counted from that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  assign phase_end   = tc & running;
  assign timer_clear = phase_end | ~running;

  // Terminal count for the phase currently in progress.
  always_comb begin
    terminal = ALLRED_TC;
    case (state)
      ALL_RED: terminal = ALLRED_TC;
      GREEN:   terminal = GREEN_TC;
      YELLOW:  terminal = YELLOW_TC;
      WALK:    terminal = WALK_TC;
      default: terminal = ALLRED_TC;
    endcase
  end

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_phase_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .terminal (terminal),
    .done     (tc)
  );

  // Phase state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ALL_RED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-phase logic: a phase only ends on its terminal count.
  always_comb begin
    state_nxt = state;
    case (state)
      ALL_RED: begin
        if (phase_end) begin
`ifdef PED_WALK_EN
          if (ped_pending && !after_walk) begin
            state_nxt = WALK;
          end else begin
            state_nxt = GREEN;
          end
`else
          state_nxt = GREEN;
`endif
        end
      end
      GREEN:   if (phase_end) state_nxt = YELLOW;
      YELLOW:  if (phase_end) state_nxt = ALL_RED;
      WALK:    if (phase_end) state_nxt = ALL_RED;
      default: state_nxt = ALL_RED;
    endcase
  end

  // Direction ownership changes only as a new green begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_dir <= DIR_W'(NUM_DIR - 1);
    end else if (state == ALL_RED && state_nxt == GREEN) begin
      active_dir <= rr_pick(active_dir, veh_req);
    end
  end

`ifdef PED_WALK_EN
  assign enter_walk = (state == ALL_RED) && (state_nxt == WALK);

  // Sticky pedestrian request, consumed on WALK entry; after_walk forces the
  // clearance following a WALK into GREEN so traffic is always served between walks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pending <= 1'b0;
      after_walk  <= 1'b0;
    end else begin
      ped_pending <= ped_req | (ped_pending & ~enter_walk);
      if (state == WALK && phase_end) begin
        after_walk <= 1'b1;
      end else if (state == ALL_RED && phase_end) begin
        after_walk <= 1'b0;
      end
    end
  end

  assign walk = (state == WALK);
`endif

  // Lamp decode: only the owning direction leaves red, and only in GREEN/YELLOW.
  always_comb begin
    red    = '1;
    yellow = '0;
    green  = '0;
    if (state == GREEN) begin
      green = NUM_DIR'(1) << active_dir;
      red   = ~green;
    end else if (state == YELLOW) begin
      yellow = NUM_DIR'(1) << active_dir;
      red    = ~yellow;
    end
  end

endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection: scoreboard bench for traffic_intersection.
// Drives a default 2-direction instance and a 4-direction instance from a
// shared reset; the pedestrian scenario is built when PED_WALK_EN is defined.
module tb_traffic_intersection;

  localparam int PH_AR = 0;
  localparam int PH_GR = 1;
  localparam int PH_YE = 2;
  localparam int PH_WK = 3;

  localparam int AR = 4;
  localparam int GR = 50;
  localparam int YE = 10;
  localparam int WK = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] veh_req;
  logic [1:0] red, yellow, green;
  logic [0:0] active_dir;
  logic [3:0] veh_req4;
  logic [3:0] red4, yellow4, green4;
  logic [1:0] active_dir4;
`ifdef PED_WALK_EN
  logic ped_req, walk, ped_req4, walk4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
    logic [1:0] dir;
    logic       w;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  traffic_intersection dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef PED_WALK_EN
    .ped_req    (ped_req),
    .walk       (walk),
`endif
    .veh_req    (veh_req),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_dir (active_dir)
  );

  traffic_intersection #(.NUM_DIR(4)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef PED_WALK_EN
    .ped_req    (ped_req4),
    .walk       (walk4),
`endif
    .veh_req    (veh_req4),
    .red        (red4),
    .yellow     (yellow4),
    .green      (green4),
    .active_dir (active_dir4)
  );

  // Continuous lamp safety check on both instances, every cycle.
  always @(negedge clk) begin
    int bad;
    bad = 0;
    for (int d = 0; d < 2; d++)
      if ($countones({red[d], yellow[d], green[d]}) != 1) bad++;
    if ($countones(~red) > 1) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL lamp_safety_2dir t=%0t: r=%b y=%b g=%b, required one lamp per dir and <=1 non-red",
               $time, red, yellow, green);
    end
    bad = 0;
    for (int d = 0; d < 4; d++)
      if ($countones({red4[d], yellow4[d], green4[d]}) != 1) bad++;
    if ($countones(~red4) > 1) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL lamp_safety_4dir t=%0t: r=%b y=%b g=%b, required one lamp per dir and <=1 non-red",
               $time, red4, yellow4, green4);
    end
  end

  // Queue n expected cycles of one phase for a unit with nd directions.
  task automatic push_phase(input int ph, input int dir, input int n, input int nd);
    exp_t e;
    e.r   = (nd == 4) ? 4'hF : 4'h3;
    e.y   = 4'h0;
    e.g   = 4'h0;
    e.dir = 2'(dir);
    e.w   = (ph == PH_WK);
    if (ph == PH_GR) begin
      e.g = 4'(1) << dir;
      e.r = e.r & ~e.g;
    end else if (ph == PH_YE) begin
      e.y = 4'(1) << dir;
      e.r = e.r & ~e.y;
    end
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Pop and compare one expected entry per cycle for n cycles.
  task automatic check_seq(input int n, input bit four, input string name);
    exp_t       e;
    logic [3:0] o_r, o_y, o_g;
    logic [1:0] o_d;
    logic       o_w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o_r = four ? red4    : {2'b00, red};
      o_y = four ? yellow4 : {2'b00, yellow};
      o_g = four ? green4  : {2'b00, green};
      o_d = four ? active_dir4 : {1'b0, active_dir};
      o_w = 1'b0;
`ifdef PED_WALK_EN
      o_w = four ? walk4 : walk;
`endif
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s t=%0t: scoreboard empty, got r=%b y=%b g=%b", name, $time, o_r, o_y, o_g);
      end else begin
        e = sb.pop_front();
`ifndef PED_WALK_EN
        e.w = 1'b0;
`endif
        if ({o_r, o_y, o_g, o_d, o_w} !== {e.r, e.y, e.g, e.dir, e.w}) begin
          n_fail++;
          $display("FAIL %s t=%0t: got r=%b y=%b g=%b dir=%0d walk=%b, expected r=%b y=%b g=%b dir=%0d walk=%b",
                   name, $time, o_r, o_y, o_g, o_d, o_w, e.r, e.y, e.g, e.dir, e.w);
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({red, yellow, green, active_dir} !== {2'b11, 2'b00, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL %s_2dir: got r=%b y=%b g=%b dir=%0d, expected r=11 y=00 g=00 dir=1",
               name, red, yellow, green, active_dir);
    end
    n_checks++;
    if ({red4, yellow4, green4, active_dir4} !== {4'hF, 4'h0, 4'h0, 2'd3}) begin
      n_fail++;
      $display("FAIL %s_4dir: got r=%b y=%b g=%b dir=%0d, expected r=1111 y=0000 g=0000 dir=3",
               name, red4, yellow4, green4, active_dir4);
    end
`ifdef PED_WALK_EN
    n_checks++;
    if ({walk, walk4} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_walk: got walk=%b walk4=%b, expected 0 0", name, walk, walk4);
    end
`endif
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    veh_req  = 2'b00;
    veh_req4 = 4'b0000;
`ifdef PED_WALK_EN
    ped_req  = 1'b0;
    ped_req4 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_hold");
  endtask

  // Default timing, veh_req changes mid-green, no-demand advance and re-serve.
  task automatic test_default();
    @(negedge clk);
    reset_n = 1'b1;
    push_phase(PH_AR, 1, AR, 2);
    push_phase(PH_GR, 0, GR, 2);
    push_phase(PH_YE, 0, YE, 2);
    push_phase(PH_AR, 0, AR, 2);
    push_phase(PH_GR, 1, GR, 2);
    push_phase(PH_YE, 1, YE, 2);
    push_phase(PH_AR, 1, AR, 2);
    push_phase(PH_GR, 1, 5, 2);
    check_seq(AR + 10, 1'b0, "default_first");
    veh_req = 2'b11;
    check_seq(20, 1'b0, "default_green_req");
    veh_req = 2'b00;
    check_seq(20 + YE + AR, 1'b0, "default_to_dir1");
    check_seq(25, 1'b0, "default_dir1_green");
    veh_req = 2'b10;
    check_seq(25 + YE + AR + 5, 1'b0, "default_reserve");
    veh_req = 2'b00;
  endtask

  // Reset asserted during the fifth yellow cycle acts without a clock.
  task automatic test_mid_yellow_reset();
    apply_reset();
    push_phase(PH_AR, 1, AR, 2);
    push_phase(PH_GR, 0, GR, 2);
    push_phase(PH_YE, 0, 4, 2);
    check_seq(AR + GR + 4, 1'b0, "midyel_pre");
    @(posedge clk);
    #2;
    n_checks++;
    if ({red, yellow, green} !== {2'b10, 2'b01, 2'b00}) begin
      n_fail++;
      $display("FAIL midyel_yellow5: got r=%b y=%b g=%b, expected r=10 y=01 g=00", red, yellow, green);
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midyel_async");
    @(negedge clk);
    reset_n = 1'b1;
    push_phase(PH_AR, 1, AR, 2);
    push_phase(PH_GR, 0, 3, 2);
    check_seq(AR + 3, 1'b0, "midyel_restart");
  endtask

  // Four directions: demand only on dir3 skips dir1 and dir2.
  task automatic test_rr_skip();
    apply_reset();
    push_phase(PH_AR, 3, AR, 4);
    push_phase(PH_GR, 0, GR, 4);
    push_phase(PH_YE, 0, YE, 4);
    push_phase(PH_AR, 0, AR, 4);
    push_phase(PH_GR, 3, 5, 4);
    check_seq(AR + 1, 1'b1, "rr4_start");
    veh_req4 = 4'b1000;
    check_seq(GR - 1 + YE + AR + 5, 1'b1, "rr4_skip");
    veh_req4 = 4'b0000;
  endtask

`ifdef PED_WALK_EN
  // One-cycle ped_req pulse during dir0 green inserts a walk phase.
  task automatic test_ped_walk();
    apply_reset();
    push_phase(PH_AR, 1, AR, 2);
    push_phase(PH_GR, 0, GR, 2);
    push_phase(PH_YE, 0, YE, 2);
    push_phase(PH_AR, 0, AR, 2);
    push_phase(PH_WK, 0, WK, 2);
    push_phase(PH_AR, 0, AR, 2);
    push_phase(PH_GR, 1, 5, 2);
    check_seq(AR + 5, 1'b0, "ped_pre");
    ped_req = 1'b1;
    check_seq(1, 1'b0, "ped_pulse");
    ped_req = 1'b0;
    check_seq(GR - 6 + YE + AR + WK + AR + 5, 1'b0, "ped_walk_seq");
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_mid_yellow_reset();
    test_rr_skip();
`ifdef PED_WALK_EN
    test_ped_walk();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_intersection.md
TRAFFIC_INTERSECTION -- requirements
Module: traffic_intersection

Interface
REQ-001 The block SHALL have parameter NUM_DIR, default 2, meaning the number of approach directions (legal range 2..4).
REQ-002 The block SHALL have parameter TIMER_W, default 8, meaning the phase timer width in bits.
REQ-003 The block SHALL have parameter GREEN_CYCLES, default 50, meaning the green duration per direction in clock cycles.
REQ-004 The block SHALL have parameter YELLOW_CYCLES, default 10, meaning the yellow duration in clock cycles.
REQ-005 The block SHALL have parameter ALLRED_CYCLES, default 4, meaning the all-red clearance duration in clock cycles.
REQ-006 The block SHALL have parameter WALK_CYCLES, default 20, meaning the pedestrian walk duration (used only with PED_WALK_EN).
REQ-007 The block SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 The block SHALL have port veh_req, input, NUM_DIR bits: per-direction vehicle demand, level-sensitive.
REQ-010 The block SHALL have ports red, yellow and green, output, NUM_DIR bits each: per-direction lamp drives.
REQ-011 The block SHALL have port active_dir, output, $clog2(NUM_DIR) bits: index of the direction currently owning the phase.
REQ-012 The block SHALL have ports ped_req (input, 1 bit, pulse or level) and walk (output, 1 bit), present only with PED_WALK_EN.

Function
REQ-013 The phase FSM SHALL have states ALL_RED, GREEN, YELLOW, plus WALK with PED_WALK_EN.
- Transitions: ALL_RED->GREEN, GREEN->YELLOW, YELLOW->ALL_RED.
REQ-014 The timer SHALL count from 0 and advance once per cycle.
- The phase SHALL end in the cycle where timer == duration-1; the timer SHALL return to 0 on that same edge.
- Each state therefore lasts exactly its parameter value in cycles.
REQ-015 active_dir SHALL update only on the ALL_RED->GREEN edge.
- New value: the first direction with veh_req set, searched round-robin from active_dir+1 mod NUM_DIR, sampling veh_req in the terminal ALL_RED cycle.
- If veh_req is all zero, the new value SHALL be active_dir+1 mod NUM_DIR.
- If only the current direction requests, that direction is re-served.
REQ-016 Lamp outputs SHALL be decoded combinationally from state and active_dir.
- Per direction, exactly one of red/yellow/green SHALL be 1.
- At most one direction SHALL be non-red; all directions SHALL be red in ALL_RED and WALK.
REQ-017 veh_req changes during GREEN or YELLOW SHALL NOT shorten or extend the phase.
REQ-018 Durations of 0, or values ≥2^TIMER_W, SHALL be rejected by an elaboration-time check.

Reset
REQ-019 While reset_n=0, the block SHALL hold state=ALL_RED, timer=0, active_dir=NUM_DIR-1 (so the first green is direction 0 when no requests are present).
- Outputs during reset: red=all ones, yellow=0, green=0, walk=0.
- Any pedestrian pending flag SHALL clear.
REQ-020 Assertion of reset in any state, including mid-YELLOW or mid-WALK, SHALL take effect immediately without waiting for a clock.
- The first full ALL_RED period SHALL start on the first clock edge after deassertion.

Configuration
REQ-021 Macro PED_WALK_EN SHALL control the pedestrian feature.
- Defined: a ped_req high in any cycle SHALL set a sticky pending flag. At the end of ALL_RED, if the flag is set, the FSM SHALL enter WALK (walk=1, all red) for WALK_CYCLES, clear the flag on WALK entry, then run ALL_RED again before the next GREEN. ped_req during WALK SHALL re-set the flag for the next cycle of phases.
- Not defined: no ped_req/walk ports, no WALK state, no pending flag.

Structure
REQ-022 Package traffic_pkg SHALL hold the phase state encoding (ALL_RED=0, GREEN=1, YELLOW=2, WALK=3) and the default duration constants.
REQ-023 Sub-module phase_timer (TIMER_W-bit counter with sync clear and a terminal-count compare output) SHALL be instantiated once.
- Round-robin selection SHALL remain in the top level.

Verification
REQ-024 Defaults, veh_req=0, release reset: 4 cycles all red -> dir0 green 50 cycles -> yellow 10 cycles -> all red 4 cycles -> dir1 green.
REQ-025 NUM_DIR=4, veh_req=4'b1000 held during dir0 GREEN: the next green SHALL be dir3, skipping dir1 and dir2.
REQ-026 Assert reset_n=0 at yellow cycle 5: all-red outputs in the same cycle; after release, 4 all-red cycles then dir0 green.
REQ-027 PED_WALK_EN, ped_req pulsed 1 cycle during dir0 GREEN: after yellow and all-red, walk=1 for 20 cycles, then 4 cycles all red, then dir1 green.
REQ-028 Every cycle of every test: per direction exactly one lamp on, and at most one direction non-red (continuous check).
